sensor_feeder: RTL and testbench

SENSOR_FEEDER -- requirements
Module: sensor_feeder

---
 rtl/sensor_feeder.sv | 123 ++++++++++++
 tb/tb_sensor_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_feeder.sv
// Debounced sensor-to-filter feeder driving a four-phase return-to-zero
// handshake (Start/Sensor rails) with acknowledge timeout and event counting.
module sensor_feeder #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RawSensor,
  input  logic             Actuator,
  output logic             Start,
  output logic             Sensor,
  output logic             Busy,
  output logic             Timeout,
  output logic [CNT_W-1:0] EventCount
);

  typedef enum logic [1:0] {IDLE, REQ, REL, ERR} state_t;

  localparam logic [8:0]  DEB_LIM  = 9'(DEB_CYCLES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        rs_m, rs_s, act_m, act_s;
  logic        rs_prev, deb, deb_q, deb_rise;
  logic [8:0]  deb_cnt, deb_stable;
  logic [15:0] tcnt;
  logic        tmo_hit;
  logic        rail, rail_nxt, busy_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rs_m  <= 1'b0;
      rs_s  <= 1'b0;
      act_m <= 1'b0;
      act_s <= 1'b0;
    end else begin
      rs_m  <= RawSensor;
      rs_s  <= rs_m;
      act_m <= Actuator;
      act_s <= act_m;
    end
  end

  // Stable-cycle count includes the current cycle, so deb follows rs_s
  // exactly DEB_CYCLES cycles after rs_s settles.
  always_comb begin
    deb_stable = DEB_LIM;
    if (rs_s != rs_prev)
      deb_stable = 9'd1;
    else if (deb_cnt < DEB_LIM)
      deb_stable = deb_cnt + 9'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rs_prev <= 1'b0;
      deb_cnt <= '0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
    end else begin
      rs_prev <= rs_s;
      deb_cnt <= deb_stable;
      deb_q   <= deb;
      if (deb_stable >= DEB_LIM)
        deb <= rs_s;
    end
  end

  assign deb_rise = deb & ~deb_q;
  assign tmo_hit  = (tcnt == TMO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      rail       <= 1'b0;
      Busy       <= 1'b0;
      Timeout    <= 1'b0;
      EventCount <= '0;
      tcnt       <= '0;
    end else begin
      state <= state_nxt;
      rail  <= rail_nxt;
      Busy  <= busy_nxt;
      if (state_nxt == ERR)
        Timeout <= 1'b1;
      if (state == REL && state_nxt == IDLE)
        EventCount <= EventCount + CNT_W'(1);
      if (state_nxt != state)
        tcnt <= '0;
      else if (state == REQ || state == REL)
        tcnt <= tcnt + 16'd1;
    end
  end

  // Acknowledge is tested before the timeout so a coincident edge completes the handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (deb_rise && !act_s) state_nxt = REQ;
      REQ: begin
        if (act_s)        state_nxt = REL;
        else if (tmo_hit) state_nxt = ERR;
      end
      REL: begin
        if (!act_s)       state_nxt = IDLE;
        else if (tmo_hit) state_nxt = ERR;
      end
      ERR: if (!act_s && !deb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rail_nxt = (state_nxt == REQ);
    busy_nxt = (state_nxt == REQ) || (state_nxt == REL);
  end

  assign Start  = rail;
  assign Sensor = rail;

endmodule

// File: tb/tb_sensor_feeder.sv
// Randomized bench for sensor_feeder: transaction-level model of the
// handshake timing windows and the completed-event count.
module tb_sensor_feeder;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic       CLK, RST, RawSensor, Actuator;
  logic       Start, Sensor, Busy, Timeout;
  logic [1:0] EventCount;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  sensor_feeder #(
    .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RawSensor(RawSensor),
    .Actuator(Actuator),
    .Start(Start),
    .Sensor(Sensor),
    .Busy(Busy),
    .Timeout(Timeout),
    .EventCount(EventCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checks++;
      if (Start !== Sensor) begin
        errors++;
        $display("FAIL rails_equal: Start=%b Sensor=%b, expected equal", Start, Sensor);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Request latency window is 2 sync + DEB + 1..2 cycles; each rail phase
  // change is 2 sync + 1 cycle after the acknowledge moves.
  task automatic run_handshake(input int ack_dly, input int rel_dly, input string tag);
    int lat;
    logic [1:0] exp_ev;
    RawSensor = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (Start === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat < DEB + 3 || lat > DEB + 4) begin
      errors++;
      $display("FAIL %s req_latency: got %0d cycles, expected %0d..%0d", tag, lat, DEB + 3, DEB + 4);
    end
    checks++;
    if ({Sensor, Busy} !== 2'b11) begin
      errors++;
      $display("FAIL %s req_outputs: Sensor,Busy=%b, expected 11", tag, {Sensor, Busy});
    end
    repeat (ack_dly) @(negedge CLK);
    Actuator = 1'b1;
    lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      if (Start === 1'b0) begin lat = i; break; end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s rail_drop: Start=%b after 3 cycles, expected 0", tag, Start);
    end
    checks++;
    if ({Sensor, Busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s rel_outputs: Sensor,Busy=%b, expected 01", tag, {Sensor, Busy});
    end
    repeat (rel_dly) @(negedge CLK);
    Actuator = 1'b0;
    lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      if (Busy === 1'b0) begin lat = i; break; end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s busy_drop: Busy=%b after 3 cycles, expected 0", tag, Busy);
    end
    exp_count++;
    exp_ev = 2'(exp_count);
    checks++;
    if (EventCount !== exp_ev) begin
      errors++;
      $display("FAIL %s event_count: got %0d, expected %0d", tag, EventCount, exp_ev);
    end
    RawSensor = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Start, Sensor, Busy, Timeout} !== 4'b0000 || EventCount !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: Start,Sensor,Busy,Timeout=%b EventCount=%0d, expected 0000 and 0",
               {Start, Sensor, Busy, Timeout}, EventCount);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    exp_count = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Start, Sensor, Busy, Timeout} !== 4'b0000 || EventCount !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: Start,Sensor,Busy,Timeout=%b EventCount=%0d, expected 0000 and 0",
               {Start, Sensor, Busy, Timeout}, EventCount);
    end
  endtask

  task automatic test_nominal();
    run_handshake(10, int'($urandom_range(1, 12)), "nominal");
  endtask

  task automatic test_glitch();
    int len;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      len = int'($urandom_range(1, DEB - 1));
      RawSensor = 1'b1;
      repeat (len) @(negedge CLK);
      RawSensor = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        @(negedge CLK);
        if (Start !== 1'b0 || Busy !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL glitch_%0d: pulse of %0d cycles produced Start=%b Busy=%b, expected 0", k, len, Start, Busy);
      end
    end
    checks++;
    if (EventCount !== 2'(exp_count)) begin
      errors++;
      $display("FAIL glitch_count: got %0d, expected %0d", EventCount, 2'(exp_count));
    end
  endtask

  task automatic test_stuck_ack();
    bit ok;
    Actuator = 1'b1;
    repeat (4) @(negedge CLK);
    RawSensor = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (Start !== 1'b0 || Busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stuck_ack: Start=%b Busy=%b, expected 0", Start, Busy);
    end
    Actuator = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (Start !== 1'b0 || Busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stuck_ack_release: Start=%b Busy=%b, expected 0 (edge dropped)", Start, Busy);
    end
    RawSensor = 1'b0;
    repeat (10) @(negedge CLK);
    checks++;
    if (EventCount !== 2'(exp_count)) begin
      errors++;
      $display("FAIL stuck_ack_count: got %0d, expected %0d", EventCount, 2'(exp_count));
    end
  endtask

  // Acknowledge reaches act_s on the exact cycle the REQ timeout expires.
  task automatic test_tie();
    run_handshake(TMO - 3, 5, "tie");
    checks++;
    if (Timeout !== 1'b0) begin
      errors++;
      $display("FAIL tie_timeout: Timeout=%b, expected 0", Timeout);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++)
      run_handshake(int'($urandom_range(1, 15)), int'($urandom_range(1, 12)), "random");
  endtask

  task automatic test_reset_mid();
    RawSensor = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (Start === 1'b1) break;
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({Start, Sensor, Busy} !== 3'b000 || EventCount !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: Start,Sensor,Busy=%b EventCount=%0d, expected 000 and 0",
               {Start, Sensor, Busy}, EventCount);
    end
    @(negedge CLK);
    RST = 1'b0;
    exp_count = 0;
    run_handshake(int'($urandom_range(1, 15)), int'($urandom_range(1, 12)), "post_reset");
  endtask

  task automatic test_timeout();
    int lat;
    bit ok;
    RawSensor = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (Start === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat < DEB + 3 || lat > DEB + 4) begin
      errors++;
      $display("FAIL timeout req_latency: got %0d cycles, expected %0d..%0d", lat, DEB + 3, DEB + 4);
    end
    repeat (TMO - 1) @(negedge CLK);
    checks++;
    if ({Start, Busy, Timeout} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_early: Start,Busy,Timeout=%b, expected 110", {Start, Busy, Timeout});
    end
    @(negedge CLK);
    checks++;
    if ({Start, Sensor, Busy, Timeout} !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_err: Start,Sensor,Busy,Timeout=%b, expected 0001", {Start, Sensor, Busy, Timeout});
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (Start !== 1'b0 || Timeout !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_hold: Start=%b Timeout=%b, expected 0 and 1", Start, Timeout);
    end
    RawSensor = 1'b0;
    repeat (12) @(negedge CLK);
    run_handshake(int'($urandom_range(1, 15)), int'($urandom_range(1, 12)), "after_err");
    checks++;
    if (Timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: Timeout=%b, expected 1", Timeout);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (Timeout !== 1'b0 || EventCount !== 2'd0) begin
      errors++;
      $display("FAIL timeout_clear: Timeout=%b EventCount=%0d, expected 0 and 0", Timeout, EventCount);
    end
    @(negedge CLK);
    RST = 1'b0;
    exp_count = 0;
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      run_handshake(int'($urandom_range(1, 15)), int'($urandom_range(1, 12)), "wrap");
      checks++;
      if (EventCount !== seq[k]) begin
        errors++;
        $display("FAIL wrap_%0d: EventCount=%0d, expected %0d", k, EventCount, seq[k]);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    RawSensor = 1'b0;
    Actuator = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_stuck_ack();
    test_tie();
    test_random();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
